// File: rtl/net_router_output_ctrl_wh.sv
// Wormhole output-port controller: round-robin arbitration among input-queue heads,
// with the port locked to the winning input from head flit to tail flit.
module net_router_output_ctrl_wh #(
  parameter int p_num_reqs  = 3,
  parameter int p_sel_nbits = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_num_reqs-1:0]  reqs,
  input  logic [p_num_reqs-1:0]  reqs_tail,
  input  logic [p_num_reqs-1:0]  reqs_domain,
  input  logic                   out_rdy,
  output logic [p_num_reqs-1:0]  grants,
  output logic                   out_val,
  output logic [p_sel_nbits-1:0] xbar_sel,
  output logic                   out_domain,
  output logic                   locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [p_sel_nbits-1:0] owner_reg;
  logic                   owner_domain_reg;
  logic [p_sel_nbits-1:0] ptr_reg;

  // Round-robin search result (only meaningful in IDLE)
  logic                   win_found;
  logic [p_sel_nbits-1:0] win_idx;
  int                     scan_sum;
  logic [p_sel_nbits-1:0] scan_idx;

  // Resolved grant for this cycle
  logic                   grant_any;
  logic [p_sel_nbits-1:0] grant_idx;
  logic                   grant_domain;

  function automatic logic [p_sel_nbits-1:0] wrap_inc(input logic [p_sel_nbits-1:0] x);
    if (x == p_sel_nbits'(p_num_reqs - 1))
      return '0;
    return x + p_sel_nbits'(1);
  endfunction

  // Scan ptr, ptr+1, ... modulo p_num_reqs; first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = 0;
    scan_idx  = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      scan_sum = int'(ptr_reg) + k;
      if (scan_sum >= p_num_reqs)
        scan_sum = scan_sum - p_num_reqs;
      scan_idx = p_sel_nbits'(scan_sum);
      if (!win_found && reqs[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // In LOCKED only the owner may be granted; its domain tag is frozen at the head flit.
  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_domain = 1'b0;
    if (!reset) begin
      if (state_reg == IDLE) begin
        grant_any    = out_rdy && win_found;
        grant_idx    = win_idx;
        grant_domain = grant_any ? reqs_domain[win_idx] : 1'b0;
      end else begin
        grant_any    = out_rdy && reqs[owner_reg];
        grant_idx    = owner_reg;
        grant_domain = owner_domain_reg;
      end
    end
  end

  for (genvar gi = 0; gi < p_num_reqs; gi++) begin : g_grant
    assign grants[gi] = grant_any && (grant_idx == p_sel_nbits'(gi));
  end

  assign out_val    = grant_any;
  assign xbar_sel   = grant_any ? grant_idx : '0;
  assign out_domain = grant_domain;
  assign locked     = !reset && (state_reg == LOCKED);

  // State advances only on a granted flit; stalls and bubbles leave everything untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      owner_reg        <= '0;
      owner_domain_reg <= 1'b0;
      ptr_reg          <= '0;
    end else if (grant_any) begin
      case (state_reg)
        IDLE: begin
          if (reqs_tail[grant_idx]) begin
            ptr_reg <= wrap_inc(grant_idx);
          end else begin
            state_reg        <= LOCKED;
            owner_reg        <= grant_idx;
            owner_domain_reg <= reqs_domain[grant_idx];
          end
        end
        LOCKED: begin
          if (reqs_tail[owner_reg]) begin
            state_reg <= IDLE;
            ptr_reg   <= wrap_inc(owner_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_router_output_ctrl_wh.sv
// Scoreboard bench for the wormhole output controller: a 3-input and a 5-input instance
// are driven with directed scenarios then random traffic, checked against a packet-level model.
module tb_net_router_output_ctrl_wh;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: 3 inputs
  logic [2:0] a_reqs, a_tail, a_dom, a_grants;
  logic       a_rdy, a_val, a_odom, a_locked;
  logic [1:0] a_sel;
  // Instance B: 5 inputs
  logic [4:0] b_reqs, b_tail, b_dom, b_grants;
  logic       b_rdy, b_val, b_odom, b_locked;
  logic [2:0] b_sel;

  net_router_output_ctrl_wh #(.p_num_reqs(3), .p_sel_nbits(2)) dut_a (
    .clk(clk), .reset(reset), .reqs(a_reqs), .reqs_tail(a_tail), .reqs_domain(a_dom),
    .out_rdy(a_rdy), .grants(a_grants), .out_val(a_val), .xbar_sel(a_sel),
    .out_domain(a_odom), .locked(a_locked));

  net_router_output_ctrl_wh #(.p_num_reqs(5), .p_sel_nbits(3)) dut_b (
    .clk(clk), .reset(reset), .reqs(b_reqs), .reqs_tail(b_tail), .reqs_domain(b_dom),
    .out_rdy(b_rdy), .grants(b_grants), .out_val(b_val), .xbar_sel(b_sel),
    .out_domain(b_odom), .locked(b_locked));

  typedef struct {
    int         inst;
    logic [7:0] grants;
    logic       val;
    int         sel;
    logic       dom;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Packet-level model: is a packet in flight, who owns the port, where the rotation starts.
  int n_of[2]     = '{3, 5};
  bit m_busy[2]   = '{0, 0};
  int m_owner[2]  = '{0, 0};
  int m_ptr[2]    = '{0, 0};
  bit m_tag[2]    = '{0, 0};

  task automatic model_step(input int inst, input logic rst, input logic [7:0] rq,
                            input logic [7:0] tl, input logic [7:0] dm, input logic rdy);
    exp_t e;
    int n, w;
    n = n_of[inst];
    e.inst = inst; e.grants = '0; e.val = 0; e.sel = 0; e.dom = 0; e.lk = 0;
    if (rst) begin
      m_busy[inst] = 0; m_owner[inst] = 0; m_ptr[inst] = 0; m_tag[inst] = 0;
    end else if (!m_busy[inst]) begin
      w = -1;
      if (rdy)
        for (int k = 0; k < n; k++)
          if (w < 0 && rq[(m_ptr[inst] + k) % n]) w = (m_ptr[inst] + k) % n;
      if (w >= 0) begin
        e.grants = 8'(1 << w); e.val = 1; e.sel = w; e.dom = dm[w];
        if (tl[w]) m_ptr[inst] = (w + 1) % n;
        else begin m_busy[inst] = 1; m_owner[inst] = w; m_tag[inst] = dm[w]; end
      end
    end else begin
      e.lk = 1;
      e.dom = m_tag[inst];
      if (rdy && rq[m_owner[inst]]) begin
        e.grants = 8'(1 << m_owner[inst]); e.val = 1; e.sel = m_owner[inst];
        if (tl[m_owner[inst]]) begin
          m_busy[inst] = 0;
          m_ptr[inst]  = (m_owner[inst] + 1) % n;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Inputs are already set; predict, then let the cycle run.
  task automatic run_cycle();
    model_step(0, reset, {5'b0, a_reqs}, {5'b0, a_tail}, {5'b0, a_dom}, a_rdy);
    model_step(1, reset, {3'b0, b_reqs}, {3'b0, b_tail}, {3'b0, b_dom}, b_rdy);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_a(input logic [2:0] rq, input logic [2:0] tl, input logic [2:0] dm,
                       input logic rdy);
    a_reqs = rq; a_tail = tl; a_dom = dm; a_rdy = rdy;
  endtask

  task automatic set_b(input logic [4:0] rq, input logic [4:0] tl, input logic [4:0] dm,
                       input logic rdy);
    b_reqs = rq; b_tail = tl; b_dom = dm; b_rdy = rdy;
  endtask

  task automatic chk(input string name, input int inst, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL cyc=%0d inst=%0d %s actual=%0d required=%0d", cyc, inst, name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.inst == 0) begin
          chk("grants", 0, int'(a_grants), int'(e.grants));
          chk("out_val", 0, int'(a_val), int'(e.val));
          chk("xbar_sel", 0, int'(a_sel), e.sel);
          chk("out_domain", 0, int'(a_odom), int'(e.dom));
          chk("locked", 0, int'(a_locked), int'(e.lk));
          $display("cyc=%0d A grants=%b sel=%0d val=%0b dom=%0b locked=%0b",
                   cyc, a_grants, a_sel, a_val, a_odom, a_locked);
        end else begin
          chk("grants", 1, int'(b_grants), int'(e.grants));
          chk("out_val", 1, int'(b_val), int'(e.val));
          chk("xbar_sel", 1, int'(b_sel), e.sel);
          chk("out_domain", 1, int'(b_odom), int'(e.dom));
          chk("locked", 1, int'(b_locked), int'(e.lk));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_a(3'b111, 3'b111, 3'b111, 1'b1);
    set_b(5'b11111, 5'b11111, 5'b11111, 1'b1);
    #1;
    run_cycle();
    run_cycle();
    reset = 1'b0;
    set_b(5'b0, 5'b0, 5'b0, 1'b1);

    // Single-flit round robin: 001, 010, 100
    repeat (3) begin set_a(3'b111, 3'b111, 3'b000, 1'b1); run_cycle(); end
    // Move ptr to 1, then a 4-flit packet from input 1 with 0 and 2 contending
    set_a(3'b001, 3'b111, 3'b000, 1'b1); run_cycle();
    repeat (3) begin set_a(3'b111, 3'b000, 3'b000, 1'b1); run_cycle(); end
    set_a(3'b111, 3'b010, 3'b000, 1'b1); run_cycle();
    set_a(3'b101, 3'b111, 3'b000, 1'b1); run_cycle();
    // Domain frozen at head flit of input 0, then an IDLE grant to input 2 with domain 0
    set_a(3'b001, 3'b000, 3'b001, 1'b1); run_cycle();
    set_a(3'b101, 3'b000, 3'b000, 1'b1); run_cycle();
    set_a(3'b101, 3'b001, 3'b000, 1'b1); run_cycle();
    set_a(3'b100, 3'b100, 3'b000, 1'b1); run_cycle();
    // Lock on input 2, stall then bubbles while input 0 requests
    set_a(3'b100, 3'b000, 3'b000, 1'b1); run_cycle();
    repeat (3) begin set_a(3'b101, 3'b000, 3'b000, 1'b0); run_cycle(); end
    repeat (2) begin set_a(3'b001, 3'b000, 3'b000, 1'b1); run_cycle(); end
    set_a(3'b101, 3'b100, 3'b000, 1'b1); run_cycle();
    // Stall in IDLE with requests pending
    set_a(3'b111, 3'b111, 3'b000, 1'b0); run_cycle();
    // Reset mid-packet, then arbitration restarts from input 0
    set_a(3'b001, 3'b111, 3'b000, 1'b1); run_cycle();
    set_a(3'b110, 3'b000, 3'b000, 1'b1); run_cycle();
    reset = 1'b1; run_cycle();
    reset = 1'b0;
    set_a(3'b110, 3'b111, 3'b000, 1'b1); run_cycle();
    set_a(3'b000, 3'b000, 3'b000, 1'b1);

    // 5-input wrap: input 4, then input 0, then ptr at 1 picks input 1 over 0
    set_b(5'b10000, 5'b11111, 5'b10000, 1'b1); run_cycle();
    set_b(5'b00001, 5'b11111, 5'b00000, 1'b1); run_cycle();
    set_b(5'b00011, 5'b11111, 5'b00000, 1'b1); run_cycle();

    // Random traffic on both instances
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] t;
      reset = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < 5; b++) t[b] = ($urandom_range(0, 2) == 0);
      set_a(3'($urandom), t[2:0], 3'($urandom), ($urandom_range(0, 3) != 0));
      for (int b = 0; b < 5; b++) t[b] = ($urandom_range(0, 2) == 0);
      set_b(5'($urandom), t, 5'($urandom), ($urandom_range(0, 3) != 0));
      run_cycle();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
